delay_pacer: RTL



---
 rtl/delay_pacer_if.sv | 29 ++
 rtl/delay_pacer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/delay_pacer_if.sv
// delay_pacer_if: bundles the pacing controls coming from delay_ctrl with the
// tick / LED chaser / active delay code that the pacer produces.
// The master side (delay_ctrl or a testbench) drives run and delay.
// The slave side (delay_pacer) drives tick, led and delay_q.
interface delay_pacer_if #(
  parameter int LED_W = 10
);
  logic             run;
  logic [3:0]       delay;
  logic             tick;
  logic [LED_W-1:0] led;
  logic [3:0]       delay_q;

  modport master (
    output run,
    output delay,
    input  tick,
    input  led,
    input  delay_q
  );

  modport slave (
    input  run,
    input  delay,
    output tick,
    output led,
    output delay_q
  );
endinterface

// File: rtl/delay_pacer.sv
// delay_pacer: turns the 4-bit delay code into a stream of one-cycle tick
// pulses with period PRESCALE * 2^delay_q, and advances a one-hot LED chaser
// on every tick. A new delay code is adopted only at a period boundary, so a
// speed change never shortens or stretches the period already in progress.
//
// Optional feature macro: DELAY_PACER_BOUNCE_EN
//   undefined -> chaser rotates left, wrapping from the top bit to bit 0
//   defined   -> chaser ping-pongs between bit 0 and bit LED_W-1 (UP/DOWN FSM)
// Counter and tick timing are the same in both builds.
module delay_pacer #(
  parameter int PRESCALE = 50000,
  parameter int LED_W    = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  delay_pacer_if.slave     bus
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [LED_W-1:0] LED_RESET = LED_W'(1);
  localparam logic [3:0] DELAY_RESET = 4'b1000;

  logic [PRE_W-1:0] pre_cnt;
  logic [15:0]      per_cnt;
  logic [15:0]      per_last;
  logic [3:0]       delay_q;
  logic             tick_q;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_next;
  logic             base_en;
  logic             term;

  // Period boundary detection: a base step ends when the prescaler hits its
  // top while running; the period ends on the base step that completes
  // 2^delay_q steps.
  assign base_en  = bus.run && (pre_cnt == PRE_MAX);
  assign per_last = (16'd1 << delay_q) - 16'd1;
  assign term     = base_en && (per_cnt == per_last);

`ifdef DELAY_PACER_BOUNCE_EN

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  dir_t             dir_q;
  dir_t             dir_next;
  logic [LED_W-1:0] led_shl;
  logic [LED_W-1:0] led_shr;

  assign led_shl = {led_q[LED_W-2:0], 1'b0};
  assign led_shr = {1'b0, led_q[LED_W-1:1]};

  // Direction state register of the ping-pong chaser.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dir_q <= UP;
    end else begin
      dir_q <= dir_next;
    end
  end

  // Next chaser position and direction; turn around when the shift lands on an end bit.
  always_comb begin
    dir_next = dir_q;
    led_next = led_q;
    if (term) begin
      case (dir_q)
        UP: begin
          led_next = led_shl;
          if (led_shl[LED_W-1]) begin
            dir_next = DOWN;
          end
        end
        DOWN: begin
          led_next = led_shr;
          if (led_shr[0]) begin
            dir_next = UP;
          end
        end
        default: begin
          dir_next = UP;
          led_next = LED_RESET;
        end
      endcase
    end
  end

`else

  // Next chaser position: rotate left on each period end, top bit wraps to bit 0.
  always_comb begin
    led_next = led_q;
    if (term) begin
      led_next = {led_q[LED_W-2:0], led_q[LED_W-1]};
    end
  end

`endif

  // Prescaler, period counter, tick pulse, delay sampling and chaser register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      per_cnt <= '0;
      delay_q <= DELAY_RESET;
      tick_q  <= 1'b0;
      led_q   <= LED_RESET;
    end else begin
      tick_q <= term;
      led_q  <= led_next;
      if (bus.run) begin
        if (base_en) begin
          pre_cnt <= '0;
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end
      if (base_en) begin
        if (term) begin
          per_cnt <= '0;
        end else begin
          per_cnt <= per_cnt + 16'd1;
        end
      end
      if (term) begin
        delay_q <= bus.delay;
      end
    end
  end

  assign bus.tick    = tick_q;
  assign bus.led     = led_q;
  assign bus.delay_q = delay_q;

endmodule
